// File: rtl/seven_seg_scan_if.sv
// Display-side bus of the 7-segment scanner: BCD digits and enable in,
// shared active-low segment bus and active-low anodes out.
interface seven_seg_scan_if;
    logic       enable;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
    logic [6:0] segments;
    logic [3:0] anodes;

    modport master (
        output enable, digit1, digit2, digit3, digit4,
        input  segments, anodes
    );

    modport slave (
        input  enable, digit1, digit2, digit3, digit4,
        output segments, anodes
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Four-digit time-multiplexed 7-segment driver with dead-time, leading-zero
// blanking and a once-per-frame snapshot of the BCD inputs.
module seven_seg_scan #(
    parameter int CLOCK_DIVIDER      = 50000,
    parameter int DEAD_CYCLES        = 500,
    parameter bit LEADING_ZERO_BLANK = 1'b1
) (
    input logic             clock,
    input logic             reset,
    seven_seg_scan_if.slave bus
);
    localparam int              PW   = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
    localparam logic [PW-1:0]   LAST = PW'(CLOCK_DIVIDER - 1);
    localparam logic [PW-1:0]   DEAD = PW'(DEAD_CYCLES);

    logic [PW-1:0] prescaler;
    logic [1:0]    index;
    logic [3:0]    shadow [4];
    logic [3:0]    shown  [4];
    logic          tick;
    logic          blank4, blank3, blank2;
    logic [3:0]    anodes_next, anodes_q;
    logic [6:0]    segments_next, segments_q;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'h0:    decode = 7'h40;
            4'h1:    decode = 7'h79;
            4'h2:    decode = 7'h24;
            4'h3:    decode = 7'h30;
            4'h4:    decode = 7'h19;
            4'h5:    decode = 7'h12;
            4'h6:    decode = 7'h02;
            4'h7:    decode = 7'h78;
            4'h8:    decode = 7'h00;
            4'h9:    decode = 7'h10;
            4'hF:    decode = 7'h7F;
            default: decode = 7'h3F;
        endcase
    endfunction

    assign tick = (prescaler == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            index     <= '0;
            // NOTE: shadow is only four nibbles and must read as blank straight
            // out of reset, so unlike a true RAM it is reset explicitly.
            for (int i = 0; i < 4; i++) shadow[i] <= 4'hF;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                index <= index + 2'd1;
                if (index == 2'd3) begin
                    shadow[0] <= bus.digit1;
                    shadow[1] <= bus.digit2;
                    shadow[2] <= bus.digit3;
                    shadow[3] <= bus.digit4;
                end
            end
        end
    end

    // A digit counts as blank for the one below it if it was zero-blanked or is 0xF.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        shown  = shadow;
        blank4 = LEADING_ZERO_BLANK && (shadow[3] == 4'h0);
        blank3 = LEADING_ZERO_BLANK && (shadow[2] == 4'h0) && (blank4 || shadow[3] == 4'hF);
        blank2 = LEADING_ZERO_BLANK && (shadow[1] == 4'h0) && (blank3 || shadow[2] == 4'hF);
        if (blank4) shown[3] = 4'hF;
        if (blank3) shown[2] = 4'hF;
        if (blank2) shown[1] = 4'hF;
    end

    always_comb begin
        segments_next = decode(shown[index]);
        anodes_next   = 4'hF;
        if (bus.enable && (prescaler >= DEAD))
            anodes_next = ~(4'b0001 << index);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            anodes_q   <= 4'hF;
            segments_q <= 7'h7F;
        end else begin
            anodes_q   <= anodes_next;
            segments_q <= segments_next;
        end
    end

    assign bus.anodes   = anodes_q;
    assign bus.segments = segments_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: two instances (blanking on/off) driven in
// lockstep with CLOCK_DIVIDER=8, DEAD_CYCLES=2; expectations are hand-computed.
module tb_seven_seg_scan;
    // Packed fields: element [3] is digit4, element [0] is digit1.
    typedef struct packed {
        logic [3:0][3:0] d;
        logic [3:0][6:0] seg;
        logic [3:0][6:0] nlz;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    seven_seg_scan_if bus ();
    seven_seg_scan_if bus_nlz ();

    seven_seg_scan #(.CLOCK_DIVIDER(8), .DEAD_CYCLES(2), .LEADING_ZERO_BLANK(1'b1)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );
    seven_seg_scan #(.CLOCK_DIVIDER(8), .DEAD_CYCLES(2), .LEADING_ZERO_BLANK(1'b0)) dut_nlz (
        .clock(clock), .reset(reset), .bus(bus_nlz)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int i, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s cycle %0d: got %h want %h", name, i, got, want);
        end
    endtask

    task automatic set_inputs(input vec_t v);
        bus.digit1 = v.d[0];     bus.digit2 = v.d[1];
        bus.digit3 = v.d[2];     bus.digit4 = v.d[3];
        bus_nlz.digit1 = v.d[0]; bus_nlz.digit2 = v.d[1];
        bus_nlz.digit3 = v.d[2]; bus_nlz.digit4 = v.d[3];
    endtask

    task automatic set_enable(input logic en);
        bus.enable     = en;
        bus_nlz.enable = en;
    endtask

    // Frame position i = 8*slot + prescaler of the state the edge registered from.
    task automatic check_cycles(input int start, input int count, input vec_t v, input logic en);
        int         k, p;
        logic [3:0] one_hot, exp_an;
        for (int i = start; i < start + count; i++) begin
            @(posedge clock);
            @(negedge clock);
            k       = i / 8;
            p       = i % 8;
            one_hot = 4'b0001 << k;
            exp_an  = (!en || p < 2) ? 4'hF : ~one_hot;
            check("anodes",       i, {4'h0, bus.anodes},       {4'h0, exp_an});
            check("segments",     i, {1'b0, bus.segments},     {1'b0, v.seg[k]});
            check("anodes_nlz",   i, {4'h0, bus_nlz.anodes},   {4'h0, exp_an});
            check("segments_nlz", i, {1'b0, bus_nlz.segments}, {1'b0, v.nlz[k]});
        end
    endtask

    task automatic check_reset_outputs(input int i);
        check("reset_anodes",       i, {4'h0, bus.anodes},       8'h0F);
        check("reset_segments",     i, {1'b0, bus.segments},     8'h7F);
        check("reset_anodes_nlz",   i, {4'h0, bus_nlz.anodes},   8'h0F);
        check("reset_segments_nlz", i, {1'b0, bus_nlz.segments}, 8'h7F);
    endtask

    vec_t vecs [9];
    vec_t blank, v1234, v5678, vrst, prev;

    initial begin
        blank = '{d: {4'hF, 4'hF, 4'hF, 4'hF},
                  seg: {7'h7F, 7'h7F, 7'h7F, 7'h7F}, nlz: {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
        v1234 = '{d: {4'h4, 4'h3, 4'h2, 4'h1},
                  seg: {7'h19, 7'h30, 7'h24, 7'h79}, nlz: {7'h19, 7'h30, 7'h24, 7'h79}};
        v5678 = '{d: {4'h5, 4'h6, 4'h7, 4'h8},
                  seg: {7'h12, 7'h02, 7'h78, 7'h00}, nlz: {7'h12, 7'h02, 7'h78, 7'h00}};
        vrst  = '{d: {4'h9, 4'hA, 4'h0, 4'h0},
                  seg: {7'h10, 7'h3F, 7'h40, 7'h40}, nlz: {7'h10, 7'h3F, 7'h40, 7'h40}};

        vecs[0] = v1234;
        vecs[1] = '{d: {4'h0, 4'h0, 4'h0, 4'h7},
                    seg: {7'h7F, 7'h7F, 7'h7F, 7'h78}, nlz: {7'h40, 7'h40, 7'h40, 7'h78}};
        vecs[2] = '{d: {4'h0, 4'h0, 4'h0, 4'h0},
                    seg: {7'h7F, 7'h7F, 7'h7F, 7'h40}, nlz: {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[3] = '{d: {4'h0, 4'h0, 4'hB, 4'h5},
                    seg: {7'h7F, 7'h7F, 7'h3F, 7'h12}, nlz: {7'h40, 7'h40, 7'h3F, 7'h12}};
        vecs[4] = '{d: {4'hF, 4'h0, 4'h0, 4'h0},
                    seg: {7'h7F, 7'h7F, 7'h7F, 7'h40}, nlz: {7'h7F, 7'h40, 7'h40, 7'h40}};
        vecs[5] = '{d: {4'hF, 4'h5, 4'h0, 4'h0},
                    seg: {7'h7F, 7'h12, 7'h40, 7'h40}, nlz: {7'h7F, 7'h12, 7'h40, 7'h40}};
        vecs[6] = '{d: {4'hE, 4'h8, 4'h9, 4'h6},
                    seg: {7'h3F, 7'h00, 7'h10, 7'h02}, nlz: {7'h3F, 7'h00, 7'h10, 7'h02}};
        vecs[7] = '{d: {4'h0, 4'h0, 4'h0, 4'hF},
                    seg: {7'h7F, 7'h7F, 7'h7F, 7'h7F}, nlz: {7'h40, 7'h40, 7'h40, 7'h7F}};
        vecs[8] = '{d: {4'h0, 4'hC, 4'h0, 4'h3},
                    seg: {7'h7F, 7'h3F, 7'h40, 7'h30}, nlz: {7'h40, 7'h3F, 7'h40, 7'h30}};

        // Reset state, then a blank first frame until the first snapshot.
        set_enable(1'b1);
        set_inputs(v1234);
        repeat (2) @(negedge clock);
        check_reset_outputs(-1);
        reset = 1'b0;
        check_cycles(0, 32, blank, 1'b1);

        // 1234 is now latched; change inputs during slot 1, no tearing.
        check_cycles(0, 12, v1234, 1'b1);
        set_inputs(v5678);
        check_cycles(12, 20, v1234, 1'b1);
        check_cycles(0, 32, v5678, 1'b1);

        // Table: the frame after applying shows the previous vector, the next shows this one.
        prev = v5678;
        for (int n = 0; n < 9; n++) begin
            set_inputs(vecs[n]);
            check_cycles(0, 32, prev, 1'b1);
            check_cycles(0, 32, vecs[n], 1'b1);
            prev = vecs[n];
        end

        // Disabled for a full frame plus part of the next; re-enable mid slot 2.
        set_enable(1'b0);
        check_cycles(0, 32, prev, 1'b0);
        check_cycles(0, 20, prev, 1'b0);
        set_enable(1'b1);
        check_cycles(20, 12, prev, 1'b1);

        // Async reset at index 2, prescaler 5, checked before any clock edge.
        check_cycles(0, 21, prev, 1'b1);
        #1 reset = 1'b1;
        #1 check_reset_outputs(21);
        set_inputs(vrst);
        repeat (2) @(negedge clock);
        check_reset_outputs(22);
        reset = 1'b0;
        check_cycles(0, 32, blank, 1'b1);
        check_cycles(0, 32, vrst, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Downstream consumer of the output peripheral's four BCD nibbles. Time-multiplexes the four digits onto one shared 7-segment bus with active-low anodes, applying a per-digit refresh scan, dead-time between digits, leading-zero blanking and a tear-free snapshot of the inputs. Sits between the output peripheral and the board's display pins.

Parameters:
CLOCK_DIVIDER, 50000, clock cycles per digit slot (50 MHz -> 1 kHz slot rate); legal range 4..2^20
DEAD_CYCLES, 500, cycles at the start of each slot with all anodes off (anti-ghosting); must be < CLOCK_DIVIDER
LEADING_ZERO_BLANK, 1, 1 = suppress leading zeros, 0 = show all digits

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = display on; 0 = all anodes off, scan keeps running
digit1  input  4  units digit (BCD 0-9, 0xF = blank, 0xA-0xE = error)
digit2  input  4  tens digit
digit3  input  4  hundreds digit
digit4  input  4  thousands digit
segments  output  7  active-low segment drive, bit order {g,f,e,d,c,b,a}
anodes  output  4  active-low digit select, bit0 = digit1 ... bit3 = digit4

Behaviour:
- Reset (async, immediate, mid-slot included): prescaler=0, index=0, shadow digits=4'hF, anodes=4'b1111, segments=7'h7F. First snapshot happens at the first wrap after reset is released.
- Prescaler counts 0..CLOCK_DIVIDER-1 and wraps. A tick occurs on the cycle it equals CLOCK_DIVIDER-1. On each tick, the 2-bit index increments and wraps 3->0.
- Snapshot: on a tick with index==3 (3->0 transition), all four inputs are latched into shadow registers in the same edge. Input changes between snapshots never reach the display, so there is no tearing within a frame.
  - Frame = 4*CLOCK_DIVIDER cycles.
- Outputs are registered: 1-cycle latency from the prescaler/index state.
  - Next anodes = 4'b1111 if enable==0 or prescaler < DEAD_CYCLES; otherwise ~(4'b0001 << index).
  - Next segments = decode of shadow[index] after blanking. Segments are driven regardless of enable or dead time; the anodes gate visibility.
- Decode (active-low):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10 (hex)
  - 0xA-0xE: dash 7'h3F (g only)
  - 0xF: blank 7'h7F
- Leading-zero blanking (LEADING_ZERO_BLANK=1), evaluated on shadow values:
  - digit4 is blanked if 0.
  - digit3 is blanked if 0 and digit4 is blank (0 or 0xF).
  - digit2 is blanked under the same rule relative to digit3.
  - digit1 is never zero-blanked, so a value of 0 shows a single "0".
  - A nonzero or error digit stops blanking for all lower digits.
- enable deassert/assert: takes effect on the next cycle's anodes. Prescaler, index and snapshot are unaffected.
- No combinational path from inputs to outputs.

Test Plan:
(All with CLOCK_DIVIDER=8, DEAD_CYCLES=2.)
1. Reset, then digits {4,3,2,1}=1,2,3,4, enable=1, run two frames.
   - Slot index k shows anodes ~(1<<k) in slot cycles 3..8, segments 79,24,30,19 for k=0..3.
   - Anodes 4'b1111 during the first 2 cycles of each slot.
2. digits=0,0,0,7 (digit4..digit1) -> only digit1 shows 7'h78; digits 2-4 show 7'h7F.
   - All zero -> digit1 shows 7'h40.
   - With LEADING_ZERO_BLANK=0: all four show 7'h40.
3. Change inputs from 1234 to 5678 mid-frame (during index 1).
   - Rest of the frame still shows 1,2,3,4.
   - Next frame shows 8,7,6,5 on digit1..digit4.
4. digit2=0xB, digit4=0 -> digit2 shows 7'h3F; digit3=0 is blanked; digit1 is unaffected.
   - digit4=0xF -> blank.
5. enable=0 for a full frame -> anodes stay 4'b1111 and the index keeps advancing.
   - Re-enable -> the next cycle shows the correct slot.
6. Assert reset mid-slot (index 2, prescaler 5).
   - Outputs go to 4'b1111/7'h7F immediately, without waiting for a clock edge.
   - After release, the first frame shows blanks until the first 3->0 snapshot.
